// File: rtl/vga_kw_irq_gen_if.sv
// Bus between the text source / keyword programmer and the keyword IRQ
// generator. The master side feeds characters and configuration; the slave
// side (the generator) returns the interrupt, match count and overrun flag.
interface vga_kw_irq_gen_if #(
  parameter int DATA_W = 8,
  parameter int KW_MAX = 4,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (KW_MAX > 1) ? $clog2(KW_MAX) : 1;
  localparam int LEN_W = IDX_W + 1;

  logic              text_in;
  logic [DATA_W-1:0] text;
  logic              kw_wr;
  logic [IDX_W-1:0]  kw_idx;
  logic [DATA_W-1:0] kw_char;
  logic [LEN_W-1:0]  kw_len;
  logic              irq_en;
  logic              irq_clr;
  logic              vga_irq;
  logic [CNT_W-1:0]  match_cnt;
  logic              overrun;

  modport master (
    output text_in, text, kw_wr, kw_idx, kw_char, kw_len, irq_en, irq_clr,
    input  vga_irq, match_cnt, overrun
  );

  modport slave (
    input  text_in, text, kw_wr, kw_idx, kw_char, kw_len, irq_en, irq_clr,
    output vga_irq, match_cnt, overrun
  );
endinterface

// File: rtl/vga_kw_irq_gen.sv
// Keyword-triggered interrupt generator for the VGA text path.
// Keeps a sliding window of the most recent accepted characters and flags a
// match whenever the newest L characters equal the programmed keyword, where
// L is the active keyword length clamped to the window depth. Matches may
// overlap. The interrupt is either a sticky level with an overrun flag or a
// one-cycle pulse per match, chosen at elaboration time.
module vga_kw_irq_gen #(
  parameter int DATA_W    = 8,
  parameter int KW_MAX    = 4,
  parameter int CNT_W     = 8,
  parameter int IRQ_LEVEL = 1
) (
  input  logic CLK,
  input  logic RST,
  vga_kw_irq_gen_if.slave bus
);

  localparam int IDX_W = (KW_MAX > 1) ? $clog2(KW_MAX) : 1;
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] KW_MAX_L = LEN_W'(KW_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Window slot 0 holds the newest character, slot KW_MAX-1 the oldest.
  logic [DATA_W-1:0] win_q    [KW_MAX];
  logic [DATA_W-1:0] win_next [KW_MAX];
  logic [DATA_W-1:0] kw_q     [KW_MAX];

  // Number of characters accepted since the last flush, saturating.
  logic [LEN_W-1:0]  fill_q;
  logic [LEN_W-1:0]  fill_next;
  logic [LEN_W-1:0]  eff_len;

  logic [KW_MAX:1]   len_hit;
  logic              len_hit_sel;
  logic              match_next;
  logic              match_pulse;
  logic [CNT_W-1:0]  cnt_q;

  // Window contents after this cycle's accept: shift in at the newest slot.
  always_comb begin
    win_next = win_q;
    if (bus.text_in) begin
      win_next[0] = bus.text;
      for (int i = 1; i < KW_MAX; i++) begin
        win_next[i] = win_q[i-1];
      end
    end
  end

  // Fill count after this cycle; a keyword write flushes the history.
  always_comb begin
    fill_next = fill_q;
    if (bus.kw_wr) begin
      fill_next = '0;
    end else if (bus.text_in && (fill_q < KW_MAX_L)) begin
      fill_next = fill_q + LEN_W'(1);
    end
  end

  assign eff_len = (bus.kw_len > KW_MAX_L) ? KW_MAX_L : bus.kw_len;

  // For every possible length l, compare the newest l characters against
  // kw[0..l-1] with kw[l-1] aligned to the newest character.
  for (genvar l = 1; l <= KW_MAX; l++) begin : g_len
    logic [l-1:0] eq;
    for (genvar j = 0; j < l; j++) begin : g_chr
      assign eq[j] = (win_next[j] == kw_q[l-1-j]);
    end
    assign len_hit[l] = &eq;
  end

  // Pick the comparison result for the active length and qualify it.
  always_comb begin
    len_hit_sel = 1'b0;
    for (int l = 1; l <= KW_MAX; l++) begin
      if (eff_len == LEN_W'(l)) begin
        len_hit_sel = len_hit[l];
      end
    end
    match_next = bus.text_in && (eff_len != '0) && (fill_next >= eff_len) && len_hit_sel;
  end

  // Window, keyword slots, fill count and the registered match pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < KW_MAX; i++) begin
        win_q[i] <= '0;
        kw_q[i]  <= '0;
      end
      fill_q      <= '0;
      match_pulse <= 1'b0;
    end else begin
      win_q       <= win_next;
      fill_q      <= fill_next;
      match_pulse <= match_next;
      if (bus.kw_wr && (int'(bus.kw_idx) < KW_MAX)) begin
        kw_q[bus.kw_idx] <= bus.kw_char;
      end
    end
  end

  // Saturating match counter; counts whether or not the IRQ is enabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (match_pulse && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;

  if (IRQ_LEVEL != 0) begin : g_level
    logic irq_q;
    logic irq_d;
    logic ovr_q;
    logic ovr_d;

    // Sticky IRQ: a clear is applied first so a coincident match still sets.
    always_comb begin
      irq_d = irq_q;
      ovr_d = ovr_q;
      if (bus.irq_clr) begin
        irq_d = 1'b0;
        ovr_d = 1'b0;
      end
      if (match_pulse) begin
        if (irq_q && !bus.irq_clr) begin
          ovr_d = 1'b1;
        end
        if (bus.irq_en) begin
          irq_d = 1'b1;
        end
      end
    end

    // IRQ and overrun registers.
    always_ff @(posedge CLK) begin
      if (RST) begin
        irq_q <= 1'b0;
        ovr_q <= 1'b0;
      end else begin
        irq_q <= irq_d;
        ovr_q <= ovr_d;
      end
    end

    assign bus.vga_irq = irq_q;
    assign bus.overrun = ovr_q;
  end else begin : g_pulse
    logic unused_clr;
    assign unused_clr  = bus.irq_clr;
    assign bus.vga_irq = match_pulse & bus.irq_en;
    assign bus.overrun = 1'b0;
  end

endmodule

// File: doc/vga_kw_irq_gen.md
Name: vga_kw_irq_gen

Overview:
- Parametrised successor to the fixed-keyword VGA interrupt generator.
- Watches the character stream written toward the VGA text path and raises an interrupt when the last kw_len accepted characters equal a runtime-programmable keyword.
- Adds programmable keyword and length, overlapping-match detection, level/pulse IRQ modes, a saturating match counter and an overrun flag.
- Sits between the text source and the CPU interrupt controller.

Parameters:
- DATA_W, 8: character width in bits.
- KW_MAX, 4: maximum keyword length in characters; sets the window depth.
- CNT_W, 8: width of the match counter.
- IRQ_LEVEL, 1: 1 gives a sticky level IRQ cleared by irq_clr; 0 gives a one-cycle pulse per match.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- text_in  in  1  character valid; text is accepted on any cycle where this is 1.
- text  in  DATA_W  character value.
- kw_wr  in  1  keyword register write strobe.
- kw_idx  in  clog2(KW_MAX)  keyword slot to write (0 = first/oldest character).
- kw_char  in  DATA_W  character value to write into slot kw_idx.
- kw_len  in  clog2(KW_MAX)+1  active keyword length; sampled on every cycle.
- irq_en  in  1  interrupt enable; match_cnt counts regardless of this input.
- irq_clr  in  1  clears the sticky IRQ and overrun (level mode only).
- vga_irq  out  1  interrupt output.
- match_cnt  out  CNT_W  number of matches, saturating.
- overrun  out  1  sticky; a match occurred while vga_irq was already high (level mode).

Behaviour:
- Reset (RST=1 at a clock edge): vga_irq=0, match_cnt=0, overrun=0; window cleared; fill counter=0; keyword slots=0.
  - Reset asserted mid-stream discards any partial match.
- Window:
  - A KW_MAX-deep shift register of DATA_W-bit characters.
  - On a cycle with text_in=1, text shifts in at the newest position.
  - On a cycle with text_in=0, the window and fill counter hold.
  - The fill counter increments on each accepted character and saturates at KW_MAX.
- Match condition:
  - Let L = min(kw_len, KW_MAX).
  - A match occurs when L>0, fill>=L, and the newest L characters equal kw[0..L-1], with kw[L-1] compared against the newest character.
  - Evaluation uses the window state after the current accept, registered.
  - match_pulse is high in the cycle after the edge that accepted the completing character (latency 1).
  - L=0 never matches.
  - Overlapping matches are detected, e.g. "AA" found twice in "AAA".
- Keyword write:
  - On kw_wr=1, kw[kw_idx] <= kw_char.
  - kw_idx >= KW_MAX is ignored.
  - Any kw_wr also sets the fill counter to 0, which flushes the partial history.
  - kw_wr and text_in in the same cycle: the write wins, the character is still shifted in, and fill becomes 0.
- IRQ, level mode:
  - On match_pulse with irq_en=1, vga_irq <= 1.
  - irq_clr=1 sets vga_irq <= 0 and overrun <= 0.
  - Set and clear in the same cycle: set wins; overrun is not set by that match.
  - Match while vga_irq=1 and no clear: overrun <= 1.
- IRQ, pulse mode:
  - vga_irq = match_pulse & irq_en, one cycle per match.
  - irq_clr has no effect; overrun stays 0.
- irq_en=0 while vga_irq is high (level mode) does not clear the IRQ; only irq_clr or RST does.
- match_cnt increments on every match_pulse and saturates at 2^CNT_W-1 (no wrap).
- kw_len changing mid-stream takes effect on the next accepted character; no flush.

Test Plan:
- KEY detect: KW_MAX=4, kw = 4B,45,59, kw_len=3, irq_en=1. Stream FF,4B,45,59 on consecutive cycles -> vga_irq rises 1 cycle after the 59 accept edge, match_cnt=1; irq_clr -> vga_irq=0 next cycle.
- Gaps and partial: stream 4B, idle 3 cycles, 45, 59 -> match. Stream 4B,45,00,59 -> no match, match_cnt unchanged.
- Overlap and saturation:
  - kw = 41,41, kw_len=2; stream 41,41,41 -> match_cnt=2.
  - CNT_W=2 with 5 matches -> match_cnt stays 3.
- Level-mode race and overrun:
  - irq_clr coincides with a new match -> vga_irq stays 1, overrun=0.
  - A second match with no clear -> overrun=1.
  - irq_clr -> both outputs 0.
- Pulse mode (IRQ_LEVEL=0): 2 matches -> exactly 2 one-cycle vga_irq pulses. irq_en=0 -> no pulses, but match_cnt still increments.
- Flush and reset:
  - kw_wr between 4B,45 and 59 -> no match.
  - RST asserted after 4B,45, then 59 -> no match, and all outputs are 0 in the cycle after RST.
  - kw_len=0 -> never matches.
